// File: rtl/pio_out_blink.sv
// -----------------------------------------------------------------------------
// pio_out_blink
//
// Avalon-MM slave output PIO with atomic set/clear/toggle access and a per-bit
// hardware blink engine. A programmable prescaler (PERIOD) flips a single
// phase bit every PERIOD cycles; bits selected by BLINK_MASK are inverted
// while phase is 1.
//
// Register map (word address):
//   0 DATA        rw
//   1 SET         wo   DATA |=  wd   (reads back DATA)
//   2 CLR         wo   DATA &= ~wd   (reads back DATA)
//   3 TOGGLE      wo   DATA ^=  wd   (reads back DATA)
//   4 BLINK_MASK  rw
//   5 PERIOD      rw   CNT_W bits; writing restarts the engine at phase 0
//   6 STATUS      ro   bit0 = phase
//   7 reserved    reads 0, writes ignored
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     word address of the register
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (upper unused bits ignored)
//   readdata    read data, combinational, zero wait state
//   out_port    pin outputs
//
// Build option:
//   PIO_OUT_REG_EN  when defined, out_port comes from a flop (one extra clk of
//                   latency, glitch-free pins); otherwise it is combinational.
// -----------------------------------------------------------------------------
module pio_out_blink #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      CNT_W     = 24,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE = 3'd3;
    localparam logic [2:0] ADDR_MASK   = 3'd4;
    localparam logic [2:0] ADDR_PERIOD = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] data_q,   data_d;
    logic [WIDTH-1:0] mask_q,   mask_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             phase_q,  phase_d;

    logic             wr_en_s;
    logic [WIDTH-1:0] wd_bits_s;
    logic [WIDTH-1:0] blink_out_s;
    logic             unused_wd_s;

    assign wr_en_s     = chipselect & ~write_n;
    assign wd_bits_s   = writedata[WIDTH-1:0];
    // Upper writedata bits are intentionally dropped for narrow builds.
    assign unused_wd_s = ^writedata;

    // Next-state logic: free-running blink engine, then register writes on top.
    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;

        if (period_q == CNT_ZERO) begin
            // Engine stopped: hold counter and phase at zero.
            cnt_d   = CNT_ZERO;
            phase_d = 1'b0;
        end else if (cnt_q == (period_q - CNT_ONE)) begin
            cnt_d   = CNT_ZERO;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_ONE;
        end

        // A PERIOD write is applied last so it overrides a terminal count
        // landing on the same edge.
        if (wr_en_s) begin
            case (address)
                ADDR_DATA:   data_d = wd_bits_s;
                ADDR_SET:    data_d = data_q | wd_bits_s;
                ADDR_CLR:    data_d = data_q & ~wd_bits_s;
                ADDR_TOGGLE: data_d = data_q ^ wd_bits_s;
                ADDR_MASK:   mask_d = wd_bits_s;
                ADDR_PERIOD: begin
                    period_d = writedata[CNT_W-1:0];
                    cnt_d    = CNT_ZERO;
                    phase_d  = 1'b0;
                end
                default: begin
                    // STATUS and reserved addresses ignore writes.
                    data_d = data_q;
                end
            endcase
        end else begin
            // No bus write this cycle; engine update above stands.
            mask_d = mask_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= RESET_VAL;
            mask_q   <= {WIDTH{1'b0}};
            period_q <= CNT_ZERO;
            cnt_q    <= CNT_ZERO;
            phase_q  <= 1'b0;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    // Read mux: independent of chipselect; write-only addresses mirror DATA.
    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLR, ADDR_TOGGLE: readdata[WIDTH-1:0] = data_q;
            ADDR_MASK:   readdata[WIDTH-1:0] = mask_q;
            ADDR_PERIOD: readdata[CNT_W-1:0] = period_q;
            ADDR_STATUS: readdata[0]         = phase_q;
            default:     readdata            = 32'h0000_0000;
        endcase
    end

    assign blink_out_s = data_q ^ (mask_q & {WIDTH{phase_q}});

`ifdef PIO_OUT_REG_EN
    logic [WIDTH-1:0] out_q;

    // Output pin register for glitch-free board outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= RESET_VAL;
        end else begin
            out_q <= blink_out_s;
        end
    end

    assign out_port = out_q;
`else
    assign out_port = blink_out_s;
`endif

endmodule

// File: tb/tb_pio_out_blink.sv
// -----------------------------------------------------------------------------
// tb_pio_out_blink
//
// Directed self-checking bench for pio_out_blink (WIDTH=8, RESET_VAL=8'hA5).
// Inputs change on the falling clock edge; outputs are sampled on the falling
// edge (out_port) or shortly after it (readdata after an address change).
// -----------------------------------------------------------------------------
module tb_pio_out_blink;

    localparam int         WIDTH = 8;
    localparam int         CNT_W = 24;
    localparam logic [7:0] RV    = 8'hA5;
`ifdef PIO_OUT_REG_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int checks = 0;
    int errors = 0;

    pio_out_blink #(
        .WIDTH     (WIDTH),
        .CNT_W     (CNT_W),
        .RESET_VAL (RV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one write for the next rising edge; returns on the following falling edge.
    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic test_reset;
        // Write held during reset must be dropped.
        address    = 3'd0;
        writedata  = 32'h0000_00FF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        repeat (3) @(negedge clk);
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        checks++;
        if (out_port !== RV) begin
            errors++;
            $display("FAIL reset_out: got %h expected %h", out_port, RV);
        end
        address = 3'd0; #1;
        checks++;
        if (readdata !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL reset_data: got %h expected %h", readdata, 32'h0000_00A5);
        end
        address = 3'd6; #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got %h expected %h", readdata, 32'h0);
        end
        address = 3'd4; #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mask: got %h expected %h", readdata, 32'h0);
        end
        address = 3'd5; #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_period: got %h expected %h", readdata, 32'h0);
        end
    endtask

    task automatic test_data_ops;
        logic [2:0]  addr_t [4];
        logic [31:0] wd_t   [4];
        logic [7:0]  exp_t  [4];
        logic [7:0]  prev;
        addr_t = '{3'd0, 3'd1, 3'd2, 3'd3};
        wd_t   = '{32'h0000_000F, 32'h0000_00F0, 32'h0000_0003, 32'h0000_0081};
        exp_t  = '{8'h0F, 8'hFF, 8'hFC, 8'h7D};
        prev   = RV;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            do_write(addr_t[i], wd_t[i]);
`ifdef PIO_OUT_REG_EN
            checks++;
            if (out_port !== prev) begin
                errors++;
                $display("FAIL out_lag_%0d: got %h expected %h", i, out_port, prev);
            end
            @(negedge clk);
`endif
            checks++;
            if (out_port !== exp_t[i]) begin
                errors++;
                $display("FAIL out_step_%0d: got %h expected %h", i, out_port, exp_t[i]);
            end
            address = 3'd0; #1;
            checks++;
            if (readdata !== {24'h0, exp_t[i]}) begin
                errors++;
                $display("FAIL data_step_%0d: got %h expected %h", i, readdata, {24'h0, exp_t[i]});
            end
            prev = exp_t[i];
            @(negedge clk);
        end
        address = 3'd3; #1;
        checks++;
        if (readdata !== 32'h0000_007D) begin
            errors++;
            $display("FAIL wo_readback: got %h expected %h", readdata, 32'h0000_007D);
        end
        @(negedge clk);
        do_write(3'd7, 32'hFFFF_FFFF);
        @(negedge clk);
        checks++;
        if (out_port !== 8'h7D) begin
            errors++;
            $display("FAIL rsvd_write_out: got %h expected %h", out_port, 8'h7D);
        end
        address = 3'd7; #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL rsvd_read: got %h expected %h", readdata, 32'h0);
        end
        @(negedge clk);
    endtask

    task automatic test_blink;
        logic [7:0] exp_o;
        logic [31:0] exp_s;
        do_write(3'd0, 32'h0);
        do_write(3'd4, 32'h1);
        do_write(3'd5, 32'h4);          // now one half-cycle after the PERIOD write edge
        address = 3'd6;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            exp_o = (k >= LAG) ? 8'(((k - LAG) / 4) % 2) : 8'h00;
            checks++;
            if (out_port !== exp_o) begin
                errors++;
                $display("FAIL blink_out_%0d: got %h expected %h", k, out_port, exp_o);
            end
            #1;
            exp_s = 32'((k / 4) % 2);
            checks++;
            if (readdata !== exp_s) begin
                errors++;
                $display("FAIL blink_phase_%0d: got %h expected %h", k, readdata, exp_s);
            end
        end
        address = 3'd5; #1;
        checks++;
        if (readdata !== 32'h4) begin
            errors++;
            $display("FAIL period_read: got %h expected %h", readdata, 32'h4);
        end
        @(negedge clk);
    endtask

    task automatic test_period_collision;
        logic [7:0] exp_o;
        logic [31:0] exp_s;
        do_write(3'd5, 32'h4);          // restart: cnt=0 after this edge
        repeat (3) @(negedge clk);      // cnt==3 now; next edge is terminal count
        do_write(3'd5, 32'h4);          // rewrite on the terminal edge
        address = 3'd6;
        for (int j = 0; j <= 5; j++) begin
            if (j > 0) @(negedge clk);
            exp_o = ((j - LAG) >= 4) ? 8'h01 : 8'h00;
            checks++;
            if (out_port !== exp_o) begin
                errors++;
                $display("FAIL coll_out_%0d: got %h expected %h", j, out_port, exp_o);
            end
            #1;
            exp_s = (j >= 4) ? 32'h1 : 32'h0;
            checks++;
            if (readdata !== exp_s) begin
                errors++;
                $display("FAIL coll_phase_%0d: got %h expected %h", j, readdata, exp_s);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_period_zero;
        do_write(3'd0, 32'h3C);
        do_write(3'd5, 32'h2);
        repeat (2) @(negedge clk);      // phase has just become 1
`ifdef PIO_OUT_REG_EN
        checks++;
        if (out_port !== 8'h3C) begin
            errors++;
            $display("FAIL pz_before: got %h expected %h", out_port, 8'h3C);
        end
`else
        checks++;
        if (out_port !== 8'h3D) begin
            errors++;
            $display("FAIL pz_before: got %h expected %h", out_port, 8'h3D);
        end
`endif
        address = 3'd6; #1;
        checks++;
        if (readdata !== 32'h1) begin
            errors++;
            $display("FAIL pz_phase1: got %h expected %h", readdata, 32'h1);
        end
        do_write(3'd5, 32'h0);
`ifdef PIO_OUT_REG_EN
        checks++;
        if (out_port !== 8'h3D) begin
            errors++;
            $display("FAIL pz_lag: got %h expected %h", out_port, 8'h3D);
        end
        @(negedge clk);
`endif
        checks++;
        if (out_port !== 8'h3C) begin
            errors++;
            $display("FAIL pz_out: got %h expected %h", out_port, 8'h3C);
        end
        address = 3'd6; #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL pz_phase0: got %h expected %h", readdata, 32'h0);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (out_port !== 8'h3C) begin
            errors++;
            $display("FAIL pz_hold_out: got %h expected %h", out_port, 8'h3C);
        end
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL pz_hold_phase: got %h expected %h", readdata, 32'h0);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        do_write(3'd5, 32'h2);
        repeat (3) @(negedge clk);      // phase is 1 at this point in both builds
        checks++;
        if (out_port !== 8'h3D) begin
            errors++;
            $display("FAIL ar_blink: got %h expected %h", out_port, 8'h3D);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_port !== RV) begin
            errors++;
            $display("FAIL ar_out: got %h expected %h", out_port, RV);
        end
        address = 3'd5; #1;             // still before the next rising edge
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL ar_period: got %h expected %h", readdata, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_port !== RV) begin
            errors++;
            $display("FAIL ar_after_out: got %h expected %h", out_port, RV);
        end
        address = 3'd4; #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL ar_mask: got %h expected %h", readdata, 32'h0);
        end
        address = 3'd6; #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL ar_status: got %h expected %h", readdata, 32'h0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        @(negedge clk);
        test_reset();
        test_data_ops();
        test_blink();
        test_period_collision();
        test_period_zero();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
